// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// Optional feature macro: FETCH_STARVE_GUARD_EN (see mem_port_arbiter.sv).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_FETCH = 2'b01,
    ARB_DATA  = 2'b10
  } arb_state_e;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_ALL  = 4'b1111;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int unsigned ctr_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch starvation guard: counts data grants issued while fetch is waiting
// and flags when fetch must be given the next arbitration slot.
// Only instantiated when FETCH_STARVE_GUARD_EN is defined.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_gnt,
  input  logic if_req,
  input  logic if_gnt,
  output logic limit_hit
);

  localparam int unsigned CNT_W = ctr_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear when fetch finally wins, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt) begin
      cnt_d = '0;
    end else if (d_gnt && if_req && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and the data stage.
// One transaction outstanding at a time; data has priority over fetch.
// A new grant can be issued in the same cycle the current access completes.
// Optional macro FETCH_STARVE_GUARD_EN: after STARVE_LIMIT data grants taken
// while fetch was waiting, the next arbitration goes to fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 30,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic xfer_done;
  logic arb_ok;
  logic grant_d;
  logic grant_f;
  logic fetch_first;

`ifdef FETCH_STARVE_GUARD_EN
  logic starve_hit;

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .d_gnt    (grant_d),
    .if_req   (if_req),
    .if_gnt   (grant_f),
    .limit_hit(starve_hit)
  );

  assign fetch_first = starve_hit & if_req;
`else
  logic unused_cfg;
  assign unused_cfg  = (STARVE_LIMIT == 0);
  assign fetch_first = 1'b0;
`endif

  // Arbitration: the port is free when idle or when the current access
  // completes this cycle. Grants are held off while reset is asserted.
  always_comb begin
    xfer_done = mem_req_q & mem_ready;
    arb_ok    = ~rst & ((state_q == ARB_IDLE) | xfer_done);
    grant_d   = arb_ok & d_req & ~fetch_first;
    grant_f   = arb_ok & if_req & ~grant_d;
  end

  // Next-state: completion bookkeeping first, then a new grant overrides
  // the return to idle so back-to-back accesses have no bubble.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;

    if (xfer_done) begin
      if (state_q == ARB_FETCH) begin
        if_valid_d = 1'b1;
        if_rdata_d = mem_rdata;
      end
      if (state_q == ARB_DATA) begin
        d_valid_d = 1'b1;
        d_rdata_d = mem_we_q ? '0 : mem_rdata;
      end
      mem_req_d = 1'b0;
      state_d   = ARB_IDLE;
    end

    if (grant_d) begin
      state_d     = ARB_DATA;
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_wstrb_d = d_wstrb;
    end else if (grant_f) begin
      state_d     = ARB_FETCH;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_wstrb_d = WSTRB_NONE;
    end
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= WSTRB_NONE;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = grant_f;
  assign d_gnt     = grant_d;
  assign d_busy    = grant_d | (state_q == ARB_DATA);
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters and memory checked every cycle
// against a transaction-level model of the port.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W       = 30;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .d_busy(d_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({if_gnt, if_valid, d_gnt, d_valid, d_busy, mem_req, mem_we}), 64'(0));
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
    chk({tag, "_d_rdata"}, 64'(d_rdata), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'(0));
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
  } txn_t;

  int          own;            // 0 none, 1 fetch, 2 data outstanding
  txn_t        cur;
  logic        ev_if, ev_d;    // valid pulses expected this cycle
  logic [DATA_W-1:0] ex_if_rdata, ex_d_rdata;
  int          starve;
  logic        f_granted, d_granted;

  task automatic model_check_step();
    logic done, free, first, eg_d, eg_f;
    done  = (own != 0) && mem_ready;
    free  = (own == 0) || mem_ready;
    first = 1'b0;
`ifdef FETCH_STARVE_GUARD_EN
    first = (starve >= int'(STARVE_LIMIT)) && if_req;
`endif
    eg_d = free && d_req && !first;
    eg_f = free && if_req && !eg_d;

    chk("if_gnt", 64'(if_gnt), 64'(eg_f));
    chk("d_gnt", 64'(d_gnt), 64'(eg_d));
    chk("mem_req", 64'(mem_req), 64'(own != 0));
    chk("d_busy", 64'(d_busy), 64'(eg_d || own == 2));
    if (own != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
      chk("mem_we", 64'(mem_we), 64'(cur.we));
      chk("mem_wstrb", 64'(mem_wstrb), 64'(cur.wstrb));
      if (own == 2) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
    end
    chk("if_valid", 64'(if_valid), 64'(ev_if));
    if (ev_if) chk("if_rdata", 64'(if_rdata), 64'(ex_if_rdata));
    chk("d_valid", 64'(d_valid), 64'(ev_d));
    if (ev_d) chk("d_rdata", 64'(d_rdata), 64'(ex_d_rdata));

    // Advance the model by one cycle.
    ev_if = done && own == 1;
    ev_d  = done && own == 2;
    if (ev_if) ex_if_rdata = mem_rdata;
    if (ev_d)  ex_d_rdata  = cur.we ? '0 : mem_rdata;
    if (eg_d) begin
      own = 2;
      cur = '{addr: d_addr, we: d_we, wdata: d_wdata, wstrb: d_wstrb};
    end else if (eg_f) begin
      own = 1;
      cur = '{addr: if_addr, we: 1'b0, wdata: '0, wstrb: WSTRB_NONE};
    end else if (done) begin
      own = 0;
    end
    if (eg_f) starve = 0;
    else if (eg_d && if_req && starve < int'(STARVE_LIMIT)) starve++;
    f_granted = eg_f;
    d_granted = eg_d;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned ready_pct, req_pct, r;
    rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0; mem_ready = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    cyc();
    rst = 1'b0;

    // Fetch only, memory ready on the third mem_req cycle.
    if_req = 1; if_addr = 30'h10;
    @(negedge clk); chk("fo_if_gnt", 64'(if_gnt), 64'(1)); chk("fo_d_busy", 64'(d_busy), 64'(0));
    cyc(); if_req = 0;
    @(negedge clk); chk("fo_mem_req", 64'(mem_req), 64'(1)); chk("fo_mem_addr", 64'(mem_addr), 64'h10);
    chk("fo_mem_we", 64'(mem_we), 64'(0)); chk("fo_mem_wstrb", 64'(mem_wstrb), 64'(0));
    cyc();
    @(negedge clk); chk("fo_early_valid", 64'(if_valid), 64'(0));
    cyc(); mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("fo_hold_req", 64'(mem_req), 64'(1));
    cyc(); mem_ready = 0;
    @(negedge clk); chk("fo_if_valid", 64'(if_valid), 64'(1)); chk("fo_if_rdata", 64'(if_rdata), 64'hDEADBEEF);
    chk("fo_req_drop", 64'(mem_req), 64'(0));
    cyc();
    @(negedge clk); chk("fo_valid_pulse", 64'(if_valid), 64'(0));

    // Simultaneous store and fetch; ready every cycle.
    cyc(); if_req = 1; if_addr = 30'h44; d_req = 1; d_we = 1; d_addr = 30'h20;
    d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    @(negedge clk); chk("sim_d_gnt", 64'(d_gnt), 64'(1)); chk("sim_if_gnt0", 64'(if_gnt), 64'(0));
    chk("sim_busy0", 64'(d_busy), 64'(1));
    cyc(); d_req = 0; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk); chk("sim_mem_we", 64'(mem_we), 64'(1)); chk("sim_mem_addr", 64'(mem_addr), 64'h20);
    chk("sim_mem_wdata", 64'(mem_wdata), 64'h12345678); chk("sim_mem_wstrb", 64'(mem_wstrb), 64'b0011);
    chk("sim_if_gnt", 64'(if_gnt), 64'(1)); chk("sim_busy1", 64'(d_busy), 64'(1));
    cyc(); if_req = 0; mem_rdata = 32'h0BADC0DE;
    @(negedge clk); chk("sim_d_valid", 64'(d_valid), 64'(1)); chk("sim_d_rdata", 64'(d_rdata), 64'(0));
    chk("sim_f_addr", 64'(mem_addr), 64'h44); chk("sim_f_we", 64'(mem_we), 64'(0));
    chk("sim_f_wstrb", 64'(mem_wstrb), 64'(0)); chk("sim_busy2", 64'(d_busy), 64'(0));
    cyc(); mem_ready = 0;
    @(negedge clk); chk("sim_if_valid", 64'(if_valid), 64'(1)); chk("sim_if_rdata", 64'(if_rdata), 64'h0BADC0DE);
    chk("sim_d_valid_end", 64'(d_valid), 64'(0)); chk("sim_idle", 64'(mem_req), 64'(0));

    // Load stalled, then reset mid-transaction.
    cyc(); d_req = 1; d_we = 0; d_addr = 30'h30;
    @(negedge clk); chk("st_d_gnt", 64'(d_gnt), 64'(1));
    cyc(); d_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("st_mem_addr", 64'(mem_addr), 64'h30); chk("st_mem_req", 64'(mem_req), 64'(1));
      chk("st_busy", 64'(d_busy), 64'(1)); chk("st_no_valid", 64'(d_valid), 64'(0));
      if (i < 3) cyc();
    end
    #2 rst = 1'b1;
    #1 check_zero("arst");
    cyc(); rst = 1'b0; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_no_valid", 64'(d_valid), 64'(0)); chk("ar_no_req", 64'(mem_req), 64'(0));
      cyc();
    end
    mem_ready = 0;

    // Randomized phase against the model (port idle, counters clear here).
    own = 0; cur = '0; ev_if = 0; ev_d = 0; ex_if_rdata = '0; ex_d_rdata = '0;
    starve = 0; f_granted = 0; d_granted = 0;
    ready_pct = 50; req_pct = 45;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(2))
          0: ready_pct = 15;
          1: ready_pct = 60;
          default: ready_pct = 100;
        endcase
        req_pct = ($urandom_range(1) == 0) ? 45 : 100;
      end
      if (c != 0) cyc();
      // Fetch requester.
      if (if_req && !f_granted) begin
        r = $urandom_range(99);
        if (r < 3 && req_pct != 100) if_req = 0;
        else if (r < 10) if_addr = 30'($urandom);
      end else begin
        if_req = ($urandom_range(99) < req_pct);
        if_addr = 30'($urandom);
      end
      // Data requester.
      if (d_req && !d_granted) begin
        r = $urandom_range(99);
        if (r < 3 && req_pct != 100) d_req = 0;
        else if (r < 10) begin d_addr = 30'($urandom); d_wdata = $urandom; end
      end else begin
        d_req   = ($urandom_range(99) < req_pct);
        d_we    = 1'($urandom_range(1));
        d_addr  = 30'($urandom);
        d_wdata = $urandom;
        d_wstrb = ($urandom_range(3) == 0) ? WSTRB_ALL : 4'($urandom);
      end
      mem_ready = ($urandom_range(99) < ready_pct);
      mem_rdata = $urandom;
      @(negedge clk);
      model_check_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between instruction fetch (si stage) and the s2 load/store stage of the 4-stage pipeline. Only one transaction is outstanding at a time. Each transaction uses a req/ready handshake toward memory. Results return to the owning requester as a one-cycle valid pulse. It also exports a busy flag so the control unit can hold fetch while a data access owns the port.

Parameters:
ADDR_W, 30, word address width (byte address bits [31:2])
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch request accepted this cycle
if_valid  out  1  fetch data returned (1-cycle pulse)
if_rdata  out  DATA_W  fetch data; meaningful only while if_valid
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data, already lane-aligned
d_wstrb  in  4  byte-lane write strobes
d_gnt  out  1  data request accepted this cycle
d_valid  out  1  load data or store ack (1-cycle pulse)
d_rdata  out  DATA_W  load data; 0 for stores
d_busy  out  1  data transaction in flight
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  4  memory strobes
mem_ready  in  1  memory completes the current request this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ready

Behaviour:
- States: ARB_IDLE, ARB_FETCH, ARB_DATA.
- Reset: state ARB_IDLE. Every output is 0, including all data and address registers.
- Arbitration happens in ARB_IDLE, or in a busy state in the same cycle mem_ready=1 (back-to-back issue, no bubble).
- Strict priority: d_req wins over if_req.
- Accepting a request:
  - The winner's gnt pulses for that one cycle.
  - Its address, we, wdata and wstrb are registered into the mem_* outputs.
  - mem_req goes to 1 next cycle; state moves to ARB_FETCH or ARB_DATA.
  - A fetch always drives mem_we=0 and mem_wstrb=0.
- Holding: mem_req and all mem_* fields stay stable until the cycle mem_ready=1 is sampled. mem_ready is ignored while mem_req=0.
- Completion (mem_ready=1):
  - The owner's valid is registered high for exactly one cycle after the ready cycle.
  - rdata is the registered mem_rdata; d_rdata is 0 for stores.
  - If no new request is granted, mem_req drops to 0 and the state returns to ARB_IDLE.
- Minimum latency: request asserted at cycle N, gnt at N, mem_req at N+1, ready at N+1 earliest, valid at N+2.
- d_busy = 1 from the d_gnt cycle through the cycle before d_valid.
- A request dropped before its gnt is legal and produces no transaction. A request changing fields before its gnt is legal; the fields sampled at gnt are the ones used.
- Simultaneous completion and new requests: the arbitration result applies in the same cycle; the previous owner's valid still fires next cycle.
- Reset asserted mid-transaction: the in-flight request is abandoned and no valid is produced. Memory must be reset on the same rst.

Optional Feature:
- Macro FETCH_STARVE_GUARD_EN.
- Defined: a counter increments on each d_gnt while if_req=1 and clears on if_gnt.
  - At STARVE_LIMIT, the next arbitration grants fetch even if d_req=1.
  - Counter width is clog2(STARVE_LIMIT+1); it resets to 0.
- Undefined: strict data priority; no counter logic.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_e enum (ARB_IDLE=2'b00, ARB_FETCH=2'b01, ARB_DATA=2'b10)
  - WSTRB_NONE=4'b0000 and WSTRB_ALL=4'b1111
- Sub-module arb_starve_ctr holds the guard counter and limit compare. It is instantiated only under FETCH_STARVE_GUARD_EN.

Test Plan:
- Fetch only: if_req=1, if_addr=0x10, memory ready after 2 cycles with rdata 0xDEADBEEF -> if_gnt at cycle 0; mem_addr=0x10, mem_we=0; if_valid at cycle 4 with if_rdata=0xDEADBEEF.
- Simultaneous requests: if_req=1 and d_req=1 (store, addr 0x20, wdata 0x12345678, wstrb 4'b0011), ready=1 immediately -> d_gnt first, mem_wstrb=4'b0011. Then if_gnt in the ready cycle with no bubble. d_valid with d_rdata=0, then if_valid.
- Back-to-back loads: d_req held high over 3 loads, mem_ready=1 every cycle -> mem_req stays 1, mem_addr advances each cycle, 3 d_valid pulses on consecutive cycles, d_busy stays 1.
- Stall: mem_ready=0 for 10 cycles -> mem_* outputs stable, no valid, d_busy=1 throughout.
- Reset mid-transaction: rst pulsed while in ARB_DATA awaiting ready -> all outputs 0 asynchronously, no d_valid afterwards, state ARB_IDLE.
- FETCH_STARVE_GUARD_EN, STARVE_LIMIT=4: d_req and if_req both continuously high -> 4 d_gnt, then 1 if_gnt, repeating. Without the macro -> if_gnt never occurs.
